// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-port arbiter and command sequencer in front of the SPI slave RAM.
//   Each requester hands over a whole write or read transaction. The arbiter
//   grants one of them, round-robin on contention, and turns the transaction
//   into the RAM's two-word command stream on ram_din:
//     top bits 00 = write address, 01 = write data,
//              10 = read address,  11 = read data.
//   The result goes back to the requester that owns the transaction. A read
//   that never sees ram_tx_valid is closed with an error after TIMEOUT cycles.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready    request handshake; ready is combinational
//   reqN_we/addr/wdata         transaction contents (wdata ignored on reads)
//   rspN_valid                 one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err         registered response payload, held until the next response
//   ram_rx_valid, ram_din      command word toward the RAM
//   ram_tx_valid, ram_dout     read return from the RAM
//   busy                       high whenever a transaction is in flight

module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [ADDR_SIZE-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [ADDR_SIZE-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 ram_rx_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  input  logic                 ram_tx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   last_grant;
  logic                   owner;
  logic                   cur_we;
  logic [ADDR_SIZE-1:0]   cur_addr;
  logic [ADDR_SIZE-1:0]   cur_wdata;
  logic [CNT_W-1:0]       wait_cnt;

  logic                   grant0;
  logic                   grant1;
  logic                   rsp_fire;
  logic                   rsp_fire_err;
  logic [ADDR_SIZE-1:0]   rsp_fire_data;
  logic                   cnt_clear;
  logic                   cnt_inc;

  // Round-robin grant. Only offered in IDLE and never while reset is
  // asserted, so a requester cannot see a handshake that the registers
  // below will not honour. On a tie, the port that did not win last time
  // takes the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Next-state and RAM command generation. The command word is a pure
  // function of the state and the latched transaction, so the RAM sees
  // address then data on consecutive cycles. rsp_fire marks the cycle in
  // which the transaction completes; the response registers capture it on
  // the following edge.
  always_comb begin
    state_next    = state;
    ram_rx_valid  = 1'b0;
    ram_din       = '0;
    rsp_fire      = 1'b0;
    rsp_fire_err  = 1'b0;
    rsp_fire_data = '0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (grant0 || grant1) state_next = ADDR;
      end
      ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(cur_we ? 2'b00 : 2'b10), cur_addr};
        state_next   = DATA;
      end
      DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(cur_we ? 2'b01 : 2'b11), (cur_we ? cur_wdata : {ADDR_SIZE{1'b0}})};
        if (cur_we) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_clear  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A returned word always beats the timeout, even on the last
        // allowed cycle.
        if (ram_tx_valid) begin
          rsp_fire      = 1'b1;
          rsp_fire_data = ram_dout;
          state_next    = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          rsp_fire     = 1'b1;
          rsp_fire_err = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, transaction latch, timeout counter and response registers.
  // Reset drops any in-flight transaction silently: no response pulse is
  // produced for it and the RAM command lines go quiet on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      wait_cnt   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      rsp0_valid <= rsp_fire && !owner;
      rsp1_valid <= rsp_fire && owner;
      if (rsp_fire) begin
        rsp_rdata <= rsp_fire_data;
        rsp_err   <= rsp_fire_err;
      end
      if (grant0 || grant1) begin
        last_grant <= grant1;
        owner      <= grant1;
        cur_we     <= grant1 ? req1_we    : req0_we;
        cur_addr   <= grant1 ? req1_addr  : req0_addr;
        cur_wdata  <= grant1 ? req1_wdata : req0_wdata;
      end
      if (cnt_clear) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a small behavioural model of the
// SPI slave RAM (1-cycle read latency, preloaded with mem[i] = i % 32).
// Inputs are driven and outputs sampled just after the falling edge.

module tb_ram_arbiter;

  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic          req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [AW-1:0] req0_wdata, req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [AW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_rx_valid;
  logic [AW+1:0] ram_din;
  logic          ram_tx_valid;
  logic [AW-1:0] ram_dout;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.ADDR_SIZE(AW), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_rx_valid (ram_rx_valid),
    .ram_din      (ram_din),
    .ram_tx_valid (ram_tx_valid),
    .ram_dout     (ram_dout),
    .busy         (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: decodes the two-word command protocol and returns
  // read data one cycle after the read-data command. ram_en lets the bench
  // silence the RAM for the timeout case; stray_tx injects a spurious
  // tx_valid.
  logic [AW-1:0] mem [256];
  logic [AW-1:0] wr_addr, rd_addr;
  logic          model_tx;
  logic          ram_en;
  logic          stray_tx;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= AW'(i % 32);
      model_tx <= 1'b0;
      ram_dout <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      model_tx <= 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[AW+1:AW])
          2'b00: wr_addr <= ram_din[AW-1:0];
          2'b01: mem[wr_addr] <= ram_din[AW-1:0];
          2'b10: rd_addr <= ram_din[AW-1:0];
          default: begin
            ram_dout <= mem[rd_addr];
            model_tx <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ram_tx_valid = (model_tx & ram_en) | stray_tx;

  // Global time limit in case a wait is ever miscounted.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic we,
                               input logic [AW-1:0] addr, input logic [AW-1:0] wdata);
    if (port == 0) begin
      req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Wait (bounded) for the next response pulse and check its contents.
  task automatic waitResponse(input string tag, input int port, input logic [AW-1:0] exp_data,
                              input logic exp_err, input int budget);
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      nextCycle();
      n++;
      if (rsp0_valid || rsp1_valid) found = 1'b1;
    end
    checkOutput({tag, "_timely"}, found, 1);
    if (found) begin
      checkOutput({tag, "_overlap"}, rsp0_valid & rsp1_valid, 0);
      checkOutput({tag, "_port"}, rsp1_valid, port);
      checkOutput({tag, "_rdata"}, rsp_rdata, exp_data);
      checkOutput({tag, "_err"}, rsp_err, exp_err);
    end
  endtask

  // Full read through one port: present, wait for ready, drop, wait result.
  task automatic doRead(input string tag, input int port, input logic [AW-1:0] addr,
                        input logic [AW-1:0] exp_data);
    int n;
    logic rdy;
    nextCycle();
    applyStimulus(port, 1'b1, 1'b0, addr, '0);
    settle();
    n = 0;
    rdy = (port == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 8) begin
      nextCycle();
      n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    checkOutput({tag, "_ready"}, rdy, 1);
    nextCycle();
    applyStimulus(port, 1'b0, 1'b0, '0, '0);
    waitResponse(tag, port, exp_data, 1'b0, 8);
  endtask

  int  g, r, last_c, k;
  logic drop_pending, pending;

  initial begin
    rst_n    = 1'b0;
    ram_en   = 1'b1;
    stray_tx = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);

    // Reset state; ready must stay low while reset is held even if valid.
    nextCycle();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 8'h11, 8'h22);
    settle();
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rx_valid", ram_rx_valid, 0);
    checkOutput("rst_din", ram_din, 0);
    checkOutput("rst_rsp", {rsp0_valid, rsp1_valid, rsp_err}, 0);
    checkOutput("rst_rdata", rsp_rdata, 0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    nextCycle();

    // Write: port 0, addr 0x3C, data 0xA5.
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 8'h3C, 8'hA5);
    settle();
    checkOutput("wr_ready0", req0_ready, 1);
    checkOutput("wr_ready1", req1_ready, 0);
    checkOutput("wr_busy_t0", busy, 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("wr_din_t1", ram_din, 10'h03C);
    checkOutput("wr_rx_t1", ram_rx_valid, 1);
    checkOutput("wr_busy_t1", busy, 1);
    checkOutput("wr_noready_busy", req0_ready, 0);
    nextCycle();
    checkOutput("wr_din_t2", ram_din, 10'h1A5);
    checkOutput("wr_rx_t2", ram_rx_valid, 1);
    checkOutput("wr_rsp_t2", rsp0_valid, 0);
    nextCycle();
    checkOutput("wr_rsp0_t3", rsp0_valid, 1);
    checkOutput("wr_rsp1_t3", rsp1_valid, 0);
    checkOutput("wr_err_t3", rsp_err, 0);
    checkOutput("wr_rdata_t3", rsp_rdata, 0);
    checkOutput("wr_idle_t3", {busy, ram_rx_valid}, 0);
    checkOutput("wr_din_t3", ram_din, 0);
    nextCycle();
    checkOutput("wr_pulse_once", rsp0_valid, 0);

    // Read: port 1, addr 0x25 -> mem = 0x05.
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 8'h25, 8'hFF);
    settle();
    checkOutput("rd_ready1", req1_ready, 1);
    checkOutput("rd_ready0", req0_ready, 0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("rd_din_t1", ram_din, 10'h225);
    nextCycle();
    checkOutput("rd_din_t2", ram_din, 10'h300);
    checkOutput("rd_rx_t2", ram_rx_valid, 1);
    nextCycle();
    checkOutput("rd_wait_busy", busy, 1);
    checkOutput("rd_wait_rx", ram_rx_valid, 0);
    checkOutput("rd_wait_din", ram_din, 0);
    checkOutput("rd_wait_rsp", rsp1_valid, 0);
    nextCycle();
    checkOutput("rd_rsp1_t4", rsp1_valid, 1);
    checkOutput("rd_rsp0_t4", rsp0_valid, 0);
    checkOutput("rd_rdata_t4", rsp_rdata, 8'h05);
    checkOutput("rd_err_t4", rsp_err, 0);

    // Contention: both ports read continuously; expect grants 0,1,0,1.
    // Port 0 reads 0x10 (-> 0x10), port 1 reads 0x33 (-> 0x13).
    g = 0;
    r = 0;
    drop_pending = 1'b0;
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 8'h10, '0);
    applyStimulus(1, 1'b1, 1'b0, 8'h33, '0);
    for (int c = 0; c < 30 && r < 4; c++) begin
      if (c > 0) nextCycle();
      if (drop_pending) begin
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        drop_pending = 1'b0;
      end
      settle();
      if (req0_ready || req1_ready) begin
        checkOutput("cont_grant_onehot", req0_ready & req1_ready, 0);
        checkOutput("cont_grant_order", req1_ready, g % 2);
        g++;
        if (g == 4) drop_pending = 1'b1;
      end
      if (rsp0_valid || rsp1_valid) begin
        checkOutput("cont_rsp_overlap", rsp0_valid & rsp1_valid, 0);
        checkOutput("cont_rsp_port", rsp1_valid, r % 2);
        checkOutput("cont_rsp_rdata", rsp_rdata, (r % 2 == 1) ? 8'h13 : 8'h10);
        r++;
      end
    end
    checkOutput("cont_grant_count", g, 4);
    checkOutput("cont_rsp_count", r, 4);

    // Timeout: RAM silent, port 0 reads 0x07; 4 WAIT cycles then error.
    nextCycle();
    ram_en = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 8'h07, '0);
    settle();
    checkOutput("to_ready0", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("to_wait_busy", busy, 1);
      checkOutput("to_wait_norsp", rsp0_valid, 0);
    end
    nextCycle();
    checkOutput("to_rsp0", rsp0_valid, 1);
    checkOutput("to_err", rsp_err, 1);
    checkOutput("to_rdata", rsp_rdata, 0);
    checkOutput("to_idle", busy, 0);
    nextCycle();
    checkOutput("to_pulse_once", rsp0_valid, 0);
    checkOutput("to_err_held", rsp_err, 1);
    stray_tx = 1'b1;
    nextCycle();
    stray_tx = 1'b0;
    settle();
    checkOutput("stray_norsp", {rsp0_valid, rsp1_valid}, 0);
    checkOutput("stray_idle", busy, 0);
    ram_en = 1'b1;

    // Reset during DATA of a port-1 read: abandoned, no response.
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 8'h01, '0);
    settle();
    checkOutput("rr_ready1", req1_ready, 1);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    nextCycle();
    checkOutput("rr_data_din", ram_din, 10'h300);
    rst_n = 1'b0;
    nextCycle();
    checkOutput("rr_busy", busy, 0);
    checkOutput("rr_rx", ram_rx_valid, 0);
    checkOutput("rr_din", ram_din, 0);
    checkOutput("rr_norsp", {rsp0_valid, rsp1_valid}, 0);
    checkOutput("rr_err", rsp_err, 0);
    checkOutput("rr_rdata", rsp_rdata, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 8'h02, '0);
    applyStimulus(1, 1'b1, 1'b0, 8'h21, '0);
    settle();
    checkOutput("rr_tie_ready0", req0_ready, 1);
    checkOutput("rr_tie_ready1", req1_ready, 0);
    checkOutput("rr_post_norsp", {rsp0_valid, rsp1_valid}, 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    waitResponse("rr_tie_rsp0", 0, 8'h02, 1'b0, 8);
    checkOutput("rr_tie_next_ready1", req1_ready, 1);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    waitResponse("rr_tie_rsp1", 1, 8'h01, 1'b0, 8);

    // Back-to-back writes on port 0: addr 0x40+k, data 0xC0+k.
    k = 0;
    last_c = 0;
    pending = 1'b0;
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 8'h40, 8'hC0);
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (c > 0) nextCycle();
      if (pending) begin
        applyStimulus(0, 1'b1, 1'b1, AW'(8'h40 + k), AW'(8'hC0 + k));
        pending = 1'b0;
      end
      settle();
      if (rsp0_valid) begin
        checkOutput("b2b_ack_err", rsp_err, 0);
        checkOutput("b2b_ack_rdata", rsp_rdata, 0);
      end
      if (req0_ready) begin
        if (k > 0) checkOutput("b2b_interval", c - last_c, 3);
        last_c = c;
        k++;
        pending = 1'b1;
      end
    end
    checkOutput("b2b_count", k, 4);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    waitResponse("b2b_last", 0, 8'h00, 1'b0, 6);

    // Read back the written locations through port 1.
    for (int i = 0; i < 4; i++) begin
      doRead("readback", 1, AW'(8'h40 + i), AW'(8'hC0 + i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and command sequencer in front of the SPI slave RAM. It accepts whole write or read transactions from two requesters, such as the SPI slave path and a local host. It grants them round-robin and converts each into the RAM's two-word command protocol on `din`[ADDR_SIZE+1:0]: 00 = write address, 01 = write data, 10 = read address, 11 = read data. It returns the read data or a write acknowledge to the owning requester, with a timeout if the RAM never raises `tx_valid`.

## Interface
- `ADDR_SIZE`, default 8: RAM address width, which is also the data width.
- `TIMEOUT`, default 15: maximum number of cycles spent waiting for RAM `tx_valid` on a read. Must be ≥1.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  transaction request. Must be held until ready.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle. Combinational.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  ADDR_SIZE  target address.
- `req0_wdata`, `req1_wdata`  in  ADDR_SIZE  write data. Ignored on reads.
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle completion pulse to the owning port.
- `rsp_rdata`  out  ADDR_SIZE  read data. 0 for writes and errors.
- `rsp_err`  out  1  qualifies `rspN_valid`. Set to 1 only on a read timeout.
- `ram_rx_valid`  out  1  drives RAM `rx_valid`.
- `ram_din`  out  ADDR_SIZE+2  drives RAM `din`.
- `ram_tx_valid`  in  1  RAM `tx_valid`.
- `ram_dout`  in  ADDR_SIZE  RAM `dout`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT.
- **IDLE:** if any `reqN_valid` is high, assert `ready` to exactly one winner, combinationally. At the clock edge:
  - latch the winner's `we`, `addr`, `wdata` and the owner index;
  - update `last_grant`;
  - go to ADDR.
- **Arbitration:**
  - If only one port is valid, it wins.
  - If both are valid, the port other than `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first contention.
- **ADDR:** `ram_rx_valid`=1, `ram_din`={we?2'b00:2'b10, addr}. Always go to DATA.
- **DATA:** `ram_rx_valid`=1, `ram_din`={we?2'b01:2'b11, we?wdata:0}.
  - Write: go to IDLE and pulse the owner's `rsp_valid` next cycle with `rdata`=0 and `err`=0.
  - Read: go to WAIT and clear the timeout counter.
- **WAIT:** `ram_rx_valid`=0. Sample `ram_tx_valid`.
  - If 1: register `ram_dout` into `rsp_rdata`, pulse the owner's `rsp_valid` next cycle with `err`=0, go to IDLE.
  - Else, if the counter equals TIMEOUT-1: pulse `rsp_valid` next cycle with `err`=1 and `rdata`=0, go to IDLE.
  - Otherwise increment the counter.
  - Counter width is $clog2(TIMEOUT+1).
- `ram_din`=0 and `ram_rx_valid`=0 in IDLE and WAIT.
- `ram_tx_valid` outside WAIT is ignored and produces no response.
- The `rsp_*` outputs are registered. `rsp_rdata` and `rsp_err` hold their values until the next response.
- A requester may drop `valid` only after `ready`. The arbiter never accepts while `busy`.

## Timing
- **Reset:**
  - state=IDLE, `last_grant`=1, counter=0;
  - `rsp0_valid`, `rsp1_valid`, `rsp_err`, `rsp_rdata`, `ram_rx_valid`, `ram_din` and `busy` all 0.
  - `reqN_ready` is forced to 0 during reset.
- **Reset mid-transaction:** the transaction is abandoned with no response. `ram_rx_valid` is 0 from the cycle after reset is sampled.
- **Write latency:** accept at T0 (IDLE), ADDR at T1, DATA at T2, `rsp_valid` at T3. The next accept is possible at T3, giving one write per 3 cycles.
- **Read latency:**
  - With the RAM's 1-cycle latency: accept at T0, ADDR at T1, DATA at T2, WAIT at T3 (RAM `tx_valid`), `rsp_valid` at T4.
  - Worst case: `rsp_valid` with `err` at T2+TIMEOUT+1.
- **Accept and response in the same cycle:** a response pulse for the previous transaction and `ready` for a new one may coincide in IDLE. Both are legal.
- The two `rspN_valid` signals are never high together.

## Test plan
- **Write:** port 0 writes addr 0x3C, data 0xA5 at T0 → `ram_din`=0x03C at T1 and 0x1A5 at T2, `ram_rx_valid` high in both, `rsp0_valid` pulse at T3 with `err`=0.
- **Read:** port 1 reads addr 0x25 from the RAM preloaded with mem[i]=i%32 → `ram_din`=0x225 then 0x300, `rsp1_valid` at T4 with `rsp_rdata`=0x05 and `err`=0.
- **Contention:** both ports continuously valid with reads → grant order is 0,1,0,1. `rsp0_valid` and `rsp1_valid` alternate and never overlap; each response carries its own port's data.
- **Timeout:** with TIMEOUT=4, `ram_tx_valid` tied 0 on a read → 4 WAIT cycles, then `rsp_valid` with `err`=1 and `rdata`=0, then IDLE. A stray `tx_valid` pulse while IDLE produces no response.
- **Reset mid-read:** `rst_n`=0 asserted during DATA → the next cycle is IDLE with all outputs 0 and no `rsp_valid`. After release, a port-0/port-1 tie grants port 0.
- **Back-to-back writes:** port 0 issues writes while port 1 is idle → accepted every 3 cycles. Read-back of the written addresses returns the written data.
